port_map_forwarder: RTL



---
 rtl/port_map_forwarder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/port_map_forwarder.sv
// Packet forwarder: buffers upstream words in a fall-through FIFO and rewrites the
// IOQ header dst mask from a per-source port map (or a flood mask) before forwarding.
module port_map_forwarder #(
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    CTRL_WIDTH      = DATA_WIDTH/8,
  parameter int                    NUM_PORTS       = 4,
  parameter int                    FIFO_DEPTH_BITS = 3,
  parameter logic [CTRL_WIDTH-1:0] IOQ_HDR_CTRL    = CTRL_WIDTH'(8'hFF),
  parameter int                    DST_POS         = 0,
  parameter int                    SRC_POS         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [CTRL_WIDTH-1:0]   in_ctrl,
  input  logic                    in_wr,
  output logic                    in_rdy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [CTRL_WIDTH-1:0]   out_ctrl,
  output logic                    out_wr,
  input  logic                    out_rdy,
  input  logic                    mode,
  input  logic [NUM_PORTS*16-1:0] port_map,
  output logic [31:0]             fwd_cnt,
  output logic [31:0]             drop_cnt,
  output logic [31:0]             err_cnt
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;

  typedef enum logic [1:0] {HDR, PASS, DROP} state_t;

  logic [DATA_WIDTH-1:0]      mem_data [DEPTH];
  logic [CTRL_WIDTH-1:0]      mem_ctrl [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [CW-1:0]              count;
  logic                       empty;
  logic                       full;
  logic                       nearly_full;
  logic                       wr_en;
  logic                       rd_en;
  logic [DATA_WIDTH-1:0]      head_data;
  logic [CTRL_WIDTH-1:0]      head_ctrl;

  state_t state;
  logic   data_seen;

  logic [15:0]           src;
  logic                  known;
  logic [15:0]           map_mask;
  logic [15:0]           flood_mask;
  logic [15:0]           mask;
  logic                  is_hdr;
  logic                  eop;
  logic [DATA_WIDTH-1:0] rewritten;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign nearly_full = (count >= CW'(DEPTH - 1));
  assign in_rdy      = !nearly_full;
  assign wr_en       = in_wr && !full;
  assign head_data   = mem_data[rd_ptr];
  assign head_ctrl   = mem_ctrl[rd_ptr];

  // DROP drains the FIFO without waiting for the downstream side.
  assign rd_en = !empty && ((state == DROP) || out_rdy);
  assign eop   = (head_ctrl != '0) && data_seen;

  always_comb begin
    src        = head_data[SRC_POS +: 16];
    known      = 1'b0;
    map_mask   = '0;
    flood_mask = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      flood_mask[2*j] = 1'b1;
      if (src == 16'(2*j)) begin
        known    = 1'b1;
        map_mask = port_map[16*j +: 16];
      end
    end
    if (known) flood_mask[src[3:0]] = 1'b0;
    mask      = mode ? flood_mask : map_mask;
    is_hdr    = (head_ctrl == IOQ_HDR_CTRL);
    rewritten = head_data;
    rewritten[DST_POS +: 16] = mask;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= in_data;
      mem_ctrl[wr_ptr] <= in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= HDR;
      data_seen <= 1'b0;
      out_wr    <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      fwd_cnt   <= '0;
      drop_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
      if (rd_en) rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
      count  <= count + CW'(wr_en) - CW'(rd_en);
      out_wr <= 1'b0;
      if (rd_en) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
        case (state)
          HDR: begin
            data_seen <= (head_ctrl == '0);
            if (is_hdr && known) begin
              if (mask != '0) begin
                out_wr   <= 1'b1;
                out_data <= rewritten;
                state    <= PASS;
              end else begin
                state <= DROP;
              end
            end else begin
              out_wr  <= 1'b1;
              err_cnt <= err_cnt + 32'd1;
              state   <= PASS;
            end
          end
          PASS: begin
            out_wr <= 1'b1;
            if (eop) begin
              fwd_cnt   <= fwd_cnt + 32'd1;
              data_seen <= 1'b0;
              state     <= HDR;
            end else if (head_ctrl == '0) begin
              data_seen <= 1'b1;
            end
          end
          DROP: begin
            if (eop) begin
              drop_cnt  <= drop_cnt + 32'd1;
              data_seen <= 1'b0;
              state     <= HDR;
            end else if (head_ctrl == '0) begin
              data_seen <= 1'b1;
            end
          end
          default: state <= HDR;
        endcase
      end
    end
  end

endmodule
